// File: rtl/aes_round_controller.sv
// Iterative AES-128 round engine: one full round per clock, encrypt or decrypt,
// with the round key fetched combinationally from the key store via key_idx_o.
module aes_round_controller #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [127:0] data_in_i,
    output logic [3:0]   key_idx_o,
    input  logic [127:0] round_key_i,
    output logic [127:0] data_out_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] dout_q, dout_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         mode_q, mode_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [127:0] enc_t, dec_t, rnd_out;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, bb;
        p  = 8'h00;
        x  = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ x;
            x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0)
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox_f(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [15:0][7:0] b;
        b = s;
        for (int i = 0; i < 16; i++)
            b[4'(i)] = inv ? isbox_f(b[4'(i)]) : sbox_f(b[4'(i)]);
        return b;
    endfunction

    // Byte n of the block sits at b[15-n]; column c, row r is byte 4c+r
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [15:0][7:0] b, o;
        int src;
        b = s;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[4'(15 - 4*c - r)] = b[4'(15 - 4*src - r)];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w, input logic inv);
        logic [7:0] a0, a1, a2, a3, m0, m1, m2, m3;
        {a0, a1, a2, a3} = w;
        m0 = inv ? 8'h0e : 8'h02;
        m1 = inv ? 8'h0b : 8'h03;
        m2 = inv ? 8'h0d : 8'h01;
        m3 = inv ? 8'h09 : 8'h01;
        return {gmul(a0, m0) ^ gmul(a1, m1) ^ gmul(a2, m2) ^ gmul(a3, m3),
                gmul(a1, m0) ^ gmul(a2, m1) ^ gmul(a3, m2) ^ gmul(a0, m3),
                gmul(a2, m0) ^ gmul(a3, m1) ^ gmul(a0, m2) ^ gmul(a1, m3),
                gmul(a3, m0) ^ gmul(a0, m1) ^ gmul(a1, m2) ^ gmul(a2, m3)};
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [3:0][31:0] w;
        w = s;
        for (int c = 0; c < 4; c++)
            w[2'(c)] = mix_word(w[2'(c)], inv);
        return w;
    endfunction

    // Decrypt uses the straight inverse cipher, so AddRoundKey precedes InvMixColumns
    always_comb begin
        enc_t = shift_rows(sub_bytes(state_q, 1'b0), 1'b0);
        if (fsm_q != S_FINAL) enc_t = mix_cols(enc_t, 1'b0);
        enc_t = enc_t ^ round_key_i;
        dec_t = sub_bytes(shift_rows(state_q, 1'b1), 1'b1) ^ round_key_i;
        if (fsm_q != S_FINAL) dec_t = mix_cols(dec_t, 1'b1);
        rnd_out = mode_q ? dec_t : enc_t;
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        dout_d    = dout_q;
        rnd_d     = rnd_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        key_idx_o = mode_q ? NR_L - rnd_q : rnd_q;
        case (fsm_q)
            S_IDLE: begin
                key_idx_o = mode_i ? NR_L : 4'd0;
                if (start_i) begin
                    state_d = data_in_i ^ round_key_i;
                    mode_d  = mode_i;
                    rnd_d   = 4'd1;
                    busy_d  = 1'b1;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = rnd_out;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == NR_L - 4'd1) fsm_d = S_FINAL;
            end
            S_FINAL: begin
                state_d = rnd_out;
                dout_d  = rnd_out;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                rnd_d   = 4'd0;
                fsm_d   = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            dout_q  <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            dout_q  <= dout_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out_o = dout_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
endmodule

// File: tb/tb_aes_round_controller.sv
// Scoreboard bench for aes_round_controller: table-driven AES reference model,
// key store model, directed FIPS-197 cases and randomized blocks.
module tb_aes_round_controller;
    logic         clk = 1'b0;
    logic         reset, start, mode;
    logic [127:0] data_in, round_key, data_out;
    logic [3:0]   key_idx;
    logic         busy, done;

    typedef struct {
        logic [127:0] res;
        int           acc;
        bit           md;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] exp_dout = '0;
    logic [127:0] rk [16];
    logic [7:0]   sbox [256];
    logic [7:0]   isbox [256];
    logic [7:0]   alog [256];
    int           lg [256];
    int           cyc = 0;
    int           cur_acc = 0;
    int           vectors = 0;
    int           miscompares = 0;
    bit           mon_en = 1'b0;
    logic [127:0] hold_data;

    localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_round_controller #(.NR(10)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
        .data_in_i(data_in), .key_idx_o(key_idx), .round_key_i(round_key),
        .data_out_o(data_out), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign round_key = rk[key_idx];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return alog[8'((lg[a] + lg[b]) % 255)];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic build_tables();
        logic [7:0] p, v, o, cst;
        p = 8'h01;
        for (int k = 0; k < 255; k++) begin
            alog[8'(k)] = p;
            lg[p] = k;
            p = p ^ xt(p);
        end
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            v = (x == 0) ? 8'h00 : alog[8'((255 - lg[8'(x)]) % 255)];
            for (int i = 0; i < 8; i++)
                o[3'(i)] = v[3'(i)] ^ v[3'(i+4)] ^ v[3'(i+5)] ^ v[3'(i+6)] ^ v[3'(i+7)] ^ cst[3'(i)];
            sbox[8'(x)] = o;
            isbox[o] = 8'(x);
        end
    endtask

    task automatic set_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [3:0][31:0] kv;
        logic [31:0] t;
        logic [7:0] rc;
        kv = k;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[6'(i)] = kv[2'(3 - i)];
        for (int i = 4; i < 44; i++) begin
            t = w[6'(i - 1)];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[6'(i)] = w[6'(i - 4)] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[4'(r)] = (r <= 10) ? {w[6'(4*r)], w[6'(4*r+1)], w[6'(4*r+2)], w[6'(4*r+3)]} : '0;
    endtask

    function automatic logic [127:0] sb_blk(input logic [127:0] s, input bit inv);
        logic [15:0][7:0] v;
        v = s;
        for (int i = 0; i < 16; i++) v[4'(i)] = inv ? isbox[v[4'(i)]] : sbox[v[4'(i)]];
        return v;
    endfunction

    function automatic logic [127:0] sh_blk(input logic [127:0] s, input bit inv);
        logic [15:0][7:0] v, o;
        int sc;
        v = s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[4'(15 - 4*c - r)] = v[4'(15 - 4*sc - r)];
            end
        return o;
    endfunction

    function automatic logic [127:0] mx_blk(input logic [127:0] s, input bit inv);
        logic [15:0][7:0] v;
        logic [7:0] coef [4];
        logic [7:0] a [4];
        logic [7:0] acc;
        v = s;
        coef[0] = inv ? 8'h0e : 8'h02;
        coef[1] = inv ? 8'h0b : 8'h03;
        coef[2] = inv ? 8'h0d : 8'h01;
        coef[3] = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[2'(j)] = v[4'(15 - 4*c - j)];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ mul(coef[2'(j - r + 4)], a[2'(j)]);
                v[4'(15 - 4*c - r)] = acc;
            end
        end
        return v;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = sh_blk(sb_blk(s, 1'b0), 1'b0);
            if (r < 10) s = mx_blk(s, 1'b0);
            s = s ^ rk[4'(r)];
        end
        return s;
    endfunction

    function automatic logic [127:0] dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            s = sb_blk(sh_blk(s, 1'b1), 1'b1) ^ rk[4'(r)];
            if (r > 0) s = mx_blk(s, 1'b1);
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle busy/done/key_idx/data_out against the scoreboard head
    always @(negedge clk) begin
        int c, acc;
        bit fl, dn, md;
        logic [3:0] ek;
        if (mon_en) begin
            c = cyc; acc = 0; fl = 1'b0; dn = 1'b0; md = 1'b0;
            if (exp_q.size() > 0) begin
                acc = exp_q[0].acc;
                md  = exp_q[0].md;
                fl  = (c >= acc) && (c < acc + 10);
                dn  = (c == acc + 10);
            end
            ek = fl ? (md ? 4'(9 - (c - acc)) : 4'(c - acc + 1)) : (mode ? 4'd10 : 4'd0);
            chk("busy", 128'(busy), 128'(fl));
            chk("done", 128'(done), 128'(dn));
            chk("key_idx", 128'(key_idx), 128'(ek));
            if (dn) begin
                exp_dout = exp_q[0].res;
                exp_q.pop_front();
            end
            chk("data_out", data_out, exp_dout);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit md, input logic [127:0] d, input logic [127:0] res);
        exp_t e;
        start   = 1'b1;
        mode    = md;
        data_in = d;
        e.res = res; e.acc = cyc + 1; e.md = md;
        exp_q.push_back(e);
        cur_acc = cyc + 1;
        tick();
        start   = 1'b0;
        mode    = 1'($urandom_range(0, 1));
        data_in = rand128();
    endtask

    // Runs the in-flight cycles; returns in the done cycle with start low
    task automatic run_busy(input bit junk, input bit hold);
        while (cyc < cur_acc + 10) begin
            if (hold) begin
                start = 1'b1; mode = 1'b1; data_in = hold_data;
            end else if (junk) begin
                start = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1)); data_in = rand128();
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        bit md;
        logic [127:0] d;
        build_tables();
        set_key(FKEY);
        reset = 1'b1; start = 1'b0; mode = 1'b0; data_in = '0;
        tick();
        mon_en = 1'b1;
        // reset holds the FSM in IDLE even with start asserted
        start = 1'b1; mode = 1'b1; data_in = FPT;
        repeat (3) tick();
        reset = 1'b0; start = 1'b0; mode = 1'b0;
        repeat (2) tick();
        // FIPS-197 encrypt then decrypt
        issue(1'b0, FPT, FCT); run_busy(1'b0, 1'b0);
        tick();
        issue(1'b1, FCT, FPT); run_busy(1'b0, 1'b0);
        repeat (2) tick();
        // start held high through a block: accepted again only in the done cycle
        hold_data = 128'hdeadbeef_0badf00d_13579bdf_2468ace0;
        issue(1'b0, FPT, FCT); run_busy(1'b0, 1'b1);
        issue(1'b1, hold_data, dec(hold_data)); run_busy(1'b0, 1'b0);
        tick();
        // back-to-back encrypt then decrypt of its result
        issue(1'b0, FPT, FCT); run_busy(1'b0, 1'b0);
        issue(1'b1, FCT, FPT); run_busy(1'b0, 1'b0);
        repeat (2) tick();
        // reset at round 5 aborts the block
        issue(1'b0, FPT, FCT);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        exp_dout = '0;
        reset = 1'b0;
        repeat (3) tick();
        issue(1'b0, FPT, FCT); run_busy(1'b0, 1'b0);
        // randomized blocks, keys, gaps and ignored starts
        for (int n = 0; n < 24; n++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) tick();
                if ($urandom_range(0, 1) == 1) set_key(rand128());
            end
            md = 1'($urandom_range(0, 1));
            d  = rand128();
            issue(md, d, md ? dec(d) : enc(d));
            run_busy(1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
        repeat (2) tick();
        chk("drain", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
